instr_trace_buffer: RTL and testbench

//  Captures retired (pc, instr) pairs from the creek core into a circular trace RAM.

---
 rtl/instr_trace_buffer_if.sv | 19 +
 rtl/instr_trace_buffer.sv | 139 +++++++++++++
 tb/tb_instr_trace_buffer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_trace_buffer_if.sv
// Avalon-MM register port of the trace buffer; host is master, buffer is slave.
// Read data is registered one cycle after the address; the slave never stalls.
interface instr_trace_buffer_if;
  logic [1:0]  avl_address;
  logic        avl_read;
  logic        avl_write;
  logic [15:0] avl_writedata;
  logic [15:0] avl_readdata;

  modport master (
    output avl_address, avl_read, avl_write, avl_writedata,
    input  avl_readdata
  );

  modport slave (
    input  avl_address, avl_read, avl_write, avl_writedata,
    output avl_readdata
  );
endinterface

// File: rtl/instr_trace_buffer.sv
// Circular trace RAM of retired (pc, instr) pairs with arm/stop/clear control, read via Avalon-MM.
// Read latency 1 clk; no stall - captures are dropped when stopped/full, pops on empty are ignored.
// Optional PC-match trigger: define TRACE_TRIGGER_EN.
module instr_trace_buffer #(
  parameter int DEPTH_LOG2   = 6,
  parameter bit STOP_ON_FULL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_trace_buffer_if.slave   avl,
  input  logic [15:0]           current_instr,
  input  logic [9:0]            current_pc,
  input  logic                  instr_valid
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [10:0]           count;
  logic                  overflow;
  logic [9:0]            trig_pc;
  logic [25:0]           mem [DEPTH];

  logic ctrl_wr, do_clear, do_stop, do_arm;
  logic empty, full, trig_hit, capture_en, wr_en, pop, drop_oldest, fill_stop;
  logic [25:0] head;

  assign ctrl_wr  = avl.avl_write && (avl.avl_address == 2'd0);
  assign do_clear = ctrl_wr && avl.avl_writedata[2];
  assign do_stop  = ctrl_wr && !avl.avl_writedata[2] && avl.avl_writedata[1];
  assign do_arm   = ctrl_wr && (avl.avl_writedata[2:1] == 2'b00) && avl.avl_writedata[0];

  assign empty = (count == 11'd0);
  assign full  = (count == 11'(DEPTH));
  assign head  = mem[rd_ptr];

`ifdef TRACE_TRIGGER_EN
  assign trig_hit = instr_valid && (current_pc == trig_pc);
`else
  assign trig_hit = 1'b0;
`endif

  // The matching instruction in ARMED is itself part of the trace.
  assign capture_en  = instr_valid && ((state == CAPTURE) || ((state == ARMED) && trig_hit));
  assign pop         = avl.avl_read && (avl.avl_address == 2'd2) && !empty && !do_clear;
  assign wr_en       = capture_en && !do_clear && (!STOP_ON_FULL || !full);
  assign drop_oldest = wr_en && full && !pop;
  assign fill_stop   = STOP_ON_FULL && !pop &&
                       (full || (wr_en && (count == 11'(DEPTH - 1))));

  always_comb begin
    state_nxt = state;
    if (do_clear) begin
      state_nxt = IDLE;
    end else if (do_stop && ((state == ARMED) || (state == CAPTURE))) begin
      state_nxt = DONE;
    end else if (do_arm && ((state == IDLE) || (state == DONE))) begin
`ifdef TRACE_TRIGGER_EN
      state_nxt = ARMED;
`else
      state_nxt = CAPTURE;
`endif
    end else if ((state == CAPTURE) || ((state == ARMED) && trig_hit)) begin
      state_nxt = fill_stop ? DONE : CAPTURE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (do_clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr_en)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop || drop_oldest)
          rd_ptr <= rd_ptr + 1'b1;
        if (drop_oldest)
          overflow <= 1'b1;
        if (wr_en && !pop && !full)
          count <= count + 11'd1;
        else if (pop && !wr_en)
          count <= count - 11'd1;
      end
    end
  end

  // Trace RAM is deliberately never scrubbed; clear only resets the pointers.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {current_pc, current_instr};
  end

`ifdef TRACE_TRIGGER_EN
  always_ff @(posedge clk) begin
    if (reset)
      trig_pc <= '0;
    else if (avl.avl_write && (avl.avl_address == 2'd3))
      trig_pc <= avl.avl_writedata[9:0];
  end
`else
  assign trig_pc = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      avl.avl_readdata <= '0;
    end else begin
      case (avl.avl_address)
        2'd0:    avl.avl_readdata <= {state, overflow, 2'b00, count};
        2'd1:    avl.avl_readdata <= empty ? 16'd0 : head[15:0];
        2'd2:    avl.avl_readdata <= empty ? 16'd0 : {6'd0, head[25:16]};
`ifdef TRACE_TRIGGER_EN
        default: avl.avl_readdata <= {6'd0, trig_pc};
`else
        default: avl.avl_readdata <= 16'd0;
`endif
      endcase
    end
  end

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Directed bench: three instances (64-deep stop-on-full, 4-deep stop-on-full, 4-deep wrap)
// share one stimulus stream; each check looks at the instance relevant to the case.
module tb_instr_trace_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        rd, wr;
  logic [15:0] wdata;
  logic [15:0] instr;
  logic [9:0]  pc;
  logic        ivld;
  logic [15:0] r0, r1, r2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  instr_trace_buffer_if if0 ();
  instr_trace_buffer_if if1 ();
  instr_trace_buffer_if if2 ();

  assign if0.avl_address = addr;  assign if0.avl_read = rd;  assign if0.avl_write = wr;  assign if0.avl_writedata = wdata;
  assign if1.avl_address = addr;  assign if1.avl_read = rd;  assign if1.avl_write = wr;  assign if1.avl_writedata = wdata;
  assign if2.avl_address = addr;  assign if2.avl_read = rd;  assign if2.avl_write = wr;  assign if2.avl_writedata = wdata;

  instr_trace_buffer #(.DEPTH_LOG2(6), .STOP_ON_FULL(1'b1)) u0 (
    .clk(clk), .reset(reset), .avl(if0),
    .current_instr(instr), .current_pc(pc), .instr_valid(ivld));
  instr_trace_buffer #(.DEPTH_LOG2(2), .STOP_ON_FULL(1'b1)) u1 (
    .clk(clk), .reset(reset), .avl(if1),
    .current_instr(instr), .current_pc(pc), .instr_valid(ivld));
  instr_trace_buffer #(.DEPTH_LOG2(2), .STOP_ON_FULL(1'b0)) u2 (
    .clk(clk), .reset(reset), .avl(if2),
    .current_instr(instr), .current_pc(pc), .instr_valid(ivld));

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] st(input logic [1:0] s, input logic ovf, input int cnt);
    logic [10:0] c;
    c = 11'(cnt);
    return {s, ovf, 2'b00, c};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    r0 = if0.avl_readdata;
    r1 = if1.avl_readdata;
    r2 = if2.avl_readdata;
  endtask

  task automatic avl_wr(input logic [1:0] a, input logic [15:0] d);
    addr = a; wdata = d; wr = 1'b1;
    cyc();
    wr = 1'b0;
  endtask

  task automatic avl_rd(input logic [1:0] a);
    addr = a; rd = 1'b1;
    cyc();
    rd = 1'b0;
    sample();
  endtask

  task automatic retire(input logic [9:0] p, input logic [15:0] i);
    pc = p; instr = i; ivld = 1'b1;
    cyc();
    ivld = 1'b0;
  endtask

  task automatic retire_and_pop(input logic [9:0] p, input logic [15:0] i);
    pc = p; instr = i; ivld = 1'b1; addr = 2'd2; rd = 1'b1;
    cyc();
    ivld = 1'b0; rd = 1'b0;
    sample();
  endtask

  task automatic arm_at(input logic [9:0] p);
`ifdef TRACE_TRIGGER_EN
    avl_wr(2'd3, {6'd0, p});
`endif
    avl_wr(2'd0, 16'h0001);
  endtask

  initial begin
    reset = 1'b1; addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
    instr = '0; pc = '0; ivld = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;

    // reset state, empty reads do not pop
    avl_rd(2'd0); check("rst_status", r0, 16'h0000);
    avl_rd(2'd1); check("rst_instr", r0, 16'h0000);
    avl_rd(2'd2); check("rst_pc", r0, 16'h0000);
    avl_rd(2'd0); check("rst_nopop", r0, 16'h0000);

    // basic capture and ordered drain
    arm_at(10'h010);
    retire(10'h010, 16'hA001);
    retire(10'h020, 16'hA002);
    retire(10'h030, 16'hA003);
    avl_rd(2'd0); check("cap3_status", r0, st(2'd2, 1'b0, 3));
    for (int i = 0; i < 3; i++) begin
      avl_rd(2'd1); check("drain_instr", r0, 16'hA001 + 16'(i));
      avl_rd(2'd2); check("drain_pc", r0, 16'h0010 * 16'(i + 1));
    end
    avl_rd(2'd0); check("drain_status", r0, st(2'd2, 1'b0, 0));

    // six retires into four slots: stop-on-full vs wrap
    avl_wr(2'd0, 16'h0004);
    arm_at(10'h010);
    for (int i = 0; i < 6; i++)
      retire(10'(16 * (i + 1)), 16'hB001 + 16'(i));
    avl_rd(2'd0);
    check("full_stop_status", r1, st(2'd3, 1'b0, 4));
    check("full_wrap_status", r2, st(2'd2, 1'b1, 4));
    check("deep_status", r0, st(2'd2, 1'b0, 6));
    avl_rd(2'd1);
    check("full_stop_head", r1, 16'hB001);
    check("full_wrap_head", r2, 16'hB003);
    for (int i = 0; i < 4; i++) begin
      avl_rd(2'd2);
      check("stop_pop_pc", r1, 16'h0010 * 16'(i + 1));
      check("wrap_pop_pc", r2, 16'h0010 * 16'(i + 3));
    end
    avl_rd(2'd0);
    check("stop_empty_status", r1, st(2'd3, 1'b0, 0));
    check("wrap_empty_status", r2, st(2'd2, 1'b1, 0));

`ifdef TRACE_TRIGGER_EN
    // PC-match trigger
    avl_wr(2'd0, 16'h0004);
    avl_wr(2'd3, 16'h0040);
    avl_wr(2'd0, 16'h0001);
    avl_rd(2'd0); check("trig_armed", r0, st(2'd1, 1'b0, 0));
    retire(10'h03C, 16'hE001);
    avl_rd(2'd0); check("trig_miss", r0, st(2'd1, 1'b0, 0));
    retire(10'h040, 16'hE002);
    avl_rd(2'd0); check("trig_hit", r0, st(2'd2, 1'b0, 1));
    retire(10'h044, 16'hE003);
    avl_rd(2'd0); check("trig_count", r0, st(2'd2, 1'b0, 2));
    avl_rd(2'd3); check("trig_reg", r0, 16'h0040);
    avl_rd(2'd2); check("trig_head_pc", r0, 16'h0040);
`else
    // no trigger: arm captures directly, address 3 inert
    avl_wr(2'd0, 16'h0004);
    avl_wr(2'd0, 16'h0001);
    avl_rd(2'd0); check("notrig_arm", r0, st(2'd2, 1'b0, 0));
    avl_wr(2'd3, 16'h0123);
    avl_rd(2'd3); check("notrig_addr3", r0, 16'h0000);
`endif

    // same-cycle capture and pop
    avl_wr(2'd0, 16'h0004);
    arm_at(10'h100);
    retire(10'h100, 16'hC001);
    retire(10'h104, 16'hC002);
    retire_and_pop(10'h108, 16'hC003);
    check("cappop_old_head", r0, 16'h0100);
    avl_rd(2'd0); check("cappop_status", r0, st(2'd2, 1'b0, 2));
    avl_rd(2'd1); check("cappop_new_head", r0, 16'hC002);

    // wrap mode full: a concurrent pop frees the slot
    avl_wr(2'd0, 16'h0004);
    arm_at(10'h200);
    for (int i = 0; i < 4; i++)
      retire(10'h200 + 10'(4 * i), 16'hD001 + 16'(i));
    retire_and_pop(10'h210, 16'hD005);
    check("wfull_pop_stop", r1, 16'h0200);
    check("wfull_pop_wrap", r2, 16'h0200);
    avl_rd(2'd0);
    check("wfull_pop_status_wrap", r2, st(2'd2, 1'b0, 4));
    check("wfull_pop_status_stop", r1, st(2'd3, 1'b0, 3));
    avl_rd(2'd1); check("wfull_pop_head", r2, 16'hD002);
    retire(10'h214, 16'hD006);
    avl_rd(2'd0); check("wfull_ovf_status", r2, st(2'd2, 1'b1, 4));
    avl_rd(2'd1); check("wfull_ovf_head", r2, 16'hD003);

    // stop, re-arm from DONE keeps entries, then clear beats everything
    avl_wr(2'd0, 16'h0004);
    arm_at(10'h300);
    retire(10'h300, 16'hF001);
    avl_wr(2'd0, 16'h0002);
    avl_rd(2'd0); check("stop_status", r0, st(2'd3, 1'b0, 1));
    avl_wr(2'd0, 16'h0001);
    avl_rd(2'd0);
`ifdef TRACE_TRIGGER_EN
    check("rearm_status", r0, st(2'd1, 1'b0, 1));
`else
    check("rearm_status", r0, st(2'd2, 1'b0, 1));
`endif
    pc = 10'h300; instr = 16'hF002; ivld = 1'b1;
    avl_wr(2'd0, 16'h0007);
    ivld = 1'b0;
    avl_rd(2'd0);
    check("clear_status", r0, 16'h0000);
    check("clear_status_wrap", r2, 16'h0000);
    avl_rd(2'd1); check("clear_head", r0, 16'h0000);

    // reset mid-capture
    arm_at(10'h010);
    retire(10'h010, 16'h1111);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    avl_rd(2'd0); check("reset_mid_status", r0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
